// File: rtl/reg_file.sv
// Integer register file: x1..x31, two combinational read ports, per-register pending-writer scoreboard.
// Define REG_FILE_BYPASS_EN to forward the same-cycle write-back onto the read ports.
module reg_file #(
   parameter int XLEN = 64,
   parameter int SB_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      write_back_i_rd,
   input  logic [XLEN-1:0] write_back_i_data,
   input  logic            write_back_i_reg_wen,
   input  logic [4:0]      decode_i_rs1,
   input  logic [4:0]      decode_i_rs2,
   output logic [XLEN-1:0] reg_file_o_rs1_data,
   output logic [XLEN-1:0] reg_file_o_rs2_data,
   output logic            reg_file_o_rs1_busy,
   output logic            reg_file_o_rs2_busy,
   input  logic            decode_i_issue_valid,
   input  logic [4:0]      decode_i_issue_rd,
   input  logic            decode_i_issue_reg_wen,
   output logic            reg_file_o_issue_ready,
   output logic            reg_file_o_sb_err
);

   localparam logic [SB_W-1:0] CNT_MAX = '1;
   localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

   // Entry 0 is reset and never written, so it stays zero.
   logic [XLEN-1:0] regs_q [0:31];
   logic [SB_W-1:0] cnt_q  [0:31];
   logic [SB_W-1:0] cnt_d  [0:31];
   logic            err_q, err_d;
   logic            wb_vld;
   logic            iss_acc;

   assign wb_vld = write_back_i_reg_wen && (write_back_i_rd != 5'd0);

   // A retiring writer to the same rd frees a slot in the same cycle.
   assign reg_file_o_issue_ready = !((decode_i_issue_rd != 5'd0) &&
                                     (cnt_q[decode_i_issue_rd] == CNT_MAX) &&
                                     !(wb_vld && (write_back_i_rd == decode_i_issue_rd)));

   assign iss_acc = decode_i_issue_valid && decode_i_issue_reg_wen &&
                    (decode_i_issue_rd != 5'd0) && reg_file_o_issue_ready;

   always_comb begin
      err_d    = err_q;
      cnt_d[0] = '0;
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         if (iss_acc && (decode_i_issue_rd == 5'(r)) &&
             !(wb_vld && (write_back_i_rd == 5'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (wb_vld && (write_back_i_rd == 5'(r)) &&
                      !(iss_acc && (decode_i_issue_rd == 5'(r)))) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         if (wb_vld) begin
            regs_q[write_back_i_rd] <= write_back_i_data;
         end
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         err_q <= err_d;
      end
   end

   always_comb begin
      reg_file_o_rs1_data = '0;
      reg_file_o_rs1_busy = 1'b0;
      if (decode_i_rs1 != 5'd0) begin
         reg_file_o_rs1_data = regs_q[decode_i_rs1];
         reg_file_o_rs1_busy = (cnt_q[decode_i_rs1] != '0);
`ifdef REG_FILE_BYPASS_EN
         // The retiring writer no longer counts, so only others keep it busy.
         if (wb_vld && (write_back_i_rd == decode_i_rs1)) begin
            reg_file_o_rs1_data = write_back_i_data;
            reg_file_o_rs1_busy = (cnt_q[decode_i_rs1] > CNT_ONE);
         end
`endif
      end
   end

   always_comb begin
      reg_file_o_rs2_data = '0;
      reg_file_o_rs2_busy = 1'b0;
      if (decode_i_rs2 != 5'd0) begin
         reg_file_o_rs2_data = regs_q[decode_i_rs2];
         reg_file_o_rs2_busy = (cnt_q[decode_i_rs2] != '0);
`ifdef REG_FILE_BYPASS_EN
         if (wb_vld && (write_back_i_rd == decode_i_rs2)) begin
            reg_file_o_rs2_data = write_back_i_data;
            reg_file_o_rs2_busy = (cnt_q[decode_i_rs2] > CNT_ONE);
         end
`endif
      end
   end

   assign reg_file_o_sb_err = err_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expectations queued when stimulus is driven, popped when outputs are sampled.
module tb_reg_file;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_wen;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy;
   logic            iss_vld;
   logic [4:0]      iss_rd;
   logic            iss_wen;
   logic            iss_rdy;
   logic            sb_err;

   int total = 0;
   int bad   = 0;

   localparam int S_D1 = 0, S_D2 = 1, S_B1 = 2, S_B2 = 3, S_RDY = 4, S_ERR = 5;

   int              exp_sel_q [$];
   logic [XLEN-1:0] exp_val_q [$];
   string           exp_tag_q [$];

   reg_file #(.XLEN(XLEN), .SB_W(2)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .write_back_i_rd        (wb_rd),
      .write_back_i_data      (wb_data),
      .write_back_i_reg_wen   (wb_wen),
      .decode_i_rs1           (rs1),
      .decode_i_rs2           (rs2),
      .reg_file_o_rs1_data    (rs1_data),
      .reg_file_o_rs2_data    (rs2_data),
      .reg_file_o_rs1_busy    (rs1_busy),
      .reg_file_o_rs2_busy    (rs2_busy),
      .decode_i_issue_valid   (iss_vld),
      .decode_i_issue_rd      (iss_rd),
      .decode_i_issue_reg_wen (iss_wen),
      .reg_file_o_issue_ready (iss_rdy),
      .reg_file_o_sb_err      (sb_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int sel, input logic [XLEN-1:0] val);
      exp_tag_q.push_back(tag);
      exp_sel_q.push_back(sel);
      exp_val_q.push_back(val);
   endtask

   function automatic logic [XLEN-1:0] observe(input int sel);
      case (sel)
         S_D1:    return rs1_data;
         S_D2:    return rs2_data;
         S_B1:    return {63'd0, rs1_busy};
         S_B2:    return {63'd0, rs2_busy};
         S_RDY:   return {63'd0, iss_rdy};
         default: return {63'd0, sb_err};
      endcase
   endfunction

   task automatic drain();
      string           tag;
      int              sel;
      logic [XLEN-1:0] exp_v;
      logic [XLEN-1:0] obs_v;
      #2;
      while (exp_sel_q.size() > 0) begin
         tag   = exp_tag_q.pop_front();
         sel   = exp_sel_q.pop_front();
         exp_v = exp_val_q.pop_front();
         obs_v = observe(sel);
         total++;
         assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
         end
      end
   endtask

   task automatic idle();
      wb_wen  = 1'b0;
      wb_rd   = 5'd0;
      wb_data = '0;
      iss_vld = 1'b0;
      iss_rd  = 5'd0;
      iss_wen = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rs1 = 5'd0;
      rs2 = 5'd0;
      idle();
      step();
      step();

      // Reset state across every address on both ports.
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         iss_rd = 5'(i);
         expect_out("rst_d1", S_D1, '0);
         expect_out("rst_d2", S_D2, '0);
         expect_out("rst_b1", S_B1, 64'd0);
         expect_out("rst_b2", S_B2, 64'd0);
         expect_out("rst_rdy", S_RDY, 64'd1);
         expect_out("rst_err", S_ERR, 64'd0);
         drain();
         step();
      end
      iss_rd = 5'd0;
      rst = 1'b0;
      step();

      // Issue x5, then retire it.
      iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd5;
      step();
      idle();
      wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF_0000_0001;
      step();
      idle();
      rs1 = 5'd5; rs2 = 5'd5;
      expect_out("x5_d1", S_D1, 64'hDEAD_BEEF_0000_0001);
      expect_out("x5_d2", S_D2, 64'hDEAD_BEEF_0000_0001);
      expect_out("x5_b1", S_B1, 64'd0);
      expect_out("x5_err", S_ERR, 64'd0);
      drain();

      // Writes to x0 are dropped entirely.
      wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234;
      step();
      idle();
      rs1 = 5'd0;
      expect_out("x0_d1", S_D1, '0);
      expect_out("x0_err", S_ERR, 64'd0);
      drain();

      // Fill x7's counter to its limit.
      for (int i = 0; i < 3; i++) begin
         iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd7;
         step();
      end
      rs1 = 5'd7;
      expect_out("x7_full_rdy", S_RDY, 64'd0);
      expect_out("x7_busy", S_B1, 64'd1);
      drain();
      wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
      expect_out("x7_wb_rdy", S_RDY, 64'd1);
      expect_out("x7_wb_busy", S_B1, 64'd1);
      drain();
      step();
      wb_wen = 1'b0;
      expect_out("x7_still_full", S_RDY, 64'd0);
      drain();
      iss_vld = 1'b0;
      wb_wen = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wb_data = 64'h70 + 64'(i);
         step();
      end
      idle();
      expect_out("x7_drained_b1", S_B1, 64'd0);
      expect_out("x7_drained_d1", S_D1, 64'h73);
      expect_out("x7_err", S_ERR, 64'd0);
      drain();

      // Write-back racing a read of the same register.
      iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd9;
      step();
      idle();
      rs2 = 5'd9;
      wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
`ifdef REG_FILE_BYPASS_EN
      expect_out("x9_same_d2", S_D2, 64'h55);
      expect_out("x9_same_b2", S_B2, 64'd0);
`else
      expect_out("x9_same_d2", S_D2, 64'h0);
      expect_out("x9_same_b2", S_B2, 64'd1);
`endif
      drain();
      step();
      idle();
      rs1 = 5'd9;
      expect_out("x9_next_d2", S_D2, 64'h55);
      expect_out("x9_next_b2", S_B2, 64'd0);
      expect_out("x9_next_d1", S_D1, 64'h55);
      drain();

      // Unexpected write-back: data lands, error sticks.
      wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'hABC;
      step();
      idle();
      rs1 = 5'd3;
      expect_out("x3_d1", S_D1, 64'hABC);
      expect_out("x3_b1", S_B1, 64'd0);
      expect_out("x3_err", S_ERR, 64'd1);
      drain();
      step();
      step();
      expect_out("x3_err_sticky", S_ERR, 64'd1);
      drain();

      // Reset forgets in-flight writers and beats a same-cycle write.
      iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd4;
      step();
      idle();
      rs1 = 5'd4;
      expect_out("x4_busy", S_B1, 64'd1);
      drain();
      rst = 1'b1;
      wb_wen = 1'b1; wb_rd = 5'd4; wb_data = 64'hFF;
      iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd4;
      step();
      rst = 1'b0;
      idle();
      rs2 = 5'd5;
      expect_out("x4_rst_b1", S_B1, 64'd0);
      expect_out("x4_rst_d1", S_D1, 64'd0);
      expect_out("x5_rst_d2", S_D2, 64'd0);
      expect_out("rst_err_clr", S_ERR, 64'd0);
      expect_out("rst_rdy", S_RDY, 64'd1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the 64-bit in-order pipeline, sitting at the far end of the write-back interface. It accepts one register write per cycle from write-back (rd, data, write enable), serves two combinational read ports to decode, and keeps a per-register in-flight writer scoreboard so decode can detect read-after-write hazards and stall. x0 is hardwired to zero and never pending.

## Interface
Parameters:
- XLEN, 64, register data width.
- SB_W, 2, width of each per-register pending-writer counter (max 2^SB_W−1 writers in flight per register).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- write_back_i_rd  input  5  destination register of the retiring instruction.
- write_back_i_data  input  XLEN  value to write.
- write_back_i_reg_wen  input  1  write strobe.
- decode_i_rs1  input  5  read port 1 address.
- decode_i_rs2  input  5  read port 2 address.
- reg_file_o_rs1_data  output  XLEN  read port 1 data.
- reg_file_o_rs2_data  output  XLEN  read port 2 data.
- reg_file_o_rs1_busy  output  1  rs1 has an uncommitted writer in flight.
- reg_file_o_rs2_busy  output  1  rs2 has an uncommitted writer in flight.
- decode_i_issue_valid  input  1  decode issuing an instruction this cycle.
- decode_i_issue_rd  input  5  destination of the issuing instruction.
- decode_i_issue_reg_wen  input  1  issuing instruction writes rd.
- reg_file_o_issue_ready  output  1  scoreboard can accept the issue.
- reg_file_o_sb_err  output  1  sticky: write-back arrived for a register with zero pending count.

## Operation
- State: 31 × XLEN registers (x1..x31), 31 × SB_W counters, 1 sticky error bit.
- Write: on edge, if write_back_i_reg_wen && write_back_i_rd != 0, reg[rd] <= data. Writes to x0 are dropped entirely (no data, no counter, no error effect).
- Read: combinational; address 0 returns 0; otherwise reg[rs] (see Configuration for bypass).
- Issue accept = decode_i_issue_valid && decode_i_issue_reg_wen && decode_i_issue_rd != 0 && reg_file_o_issue_ready.
- reg_file_o_issue_ready = 0 only when issue_rd != 0 and cnt[issue_rd] == 2^SB_W−1 and no write-back retires that same rd this cycle; otherwise 1. Decode must hold the instruction while ready is low.
- Counter update per register r, per edge: +1 on accepted issue to r, −1 on write-back to r with cnt>0; both together → unchanged.
- Write-back to r with cnt[r]==0 (and no same-cycle issue to r): data still written, counter stays 0, reg_file_o_sb_err set; it clears only on rst.
- Busy: rs_busy = (rs != 0) && effective count > 0, where effective count is defined in Configuration. The issuing instruction's own rd does not affect the busy outputs in the same cycle.

## Timing
- Reset: all registers 0, all counters 0, sb_err 0; during/after reset rs*_data = 0, rs*_busy = 0, issue_ready = 1.
- Write latency: written value visible on read ports the cycle after the write edge (0 cycles with bypass).
- Counter latency: accepted issue makes rd busy from the next cycle.
- rst asserted mid-operation overrides any same-cycle write or issue; in-flight writers are forgotten.
- Both read ports may address the same register, including the one being written; both return identical values.

## Configuration
- REG_FILE_BYPASS_EN defined: write-through forwarding. If write_back_i_reg_wen && write_back_i_rd == rs && rs != 0, rs_data = write_back_i_data in the same cycle, and effective count = cnt[rs] − 1 (so a sole pending writer retiring now reports not busy).
- Undefined: rs_data is the stored value only; effective count = cnt[rs]; decode sees the retiring value one cycle later.

## Test plan
- Reset then read x0..x31 -> all data 0, busy 0, issue_ready 1, sb_err 0.
- Write x5=0xDEAD_BEEF_0000_0001, read rs1=5 next cycle -> 0xDEAD_BEEF_0000_0001; write x0=0x1234 -> rs1=0 still reads 0.
- Issue rd=7 three times (SB_W=2) -> rs1=7 busy, fourth issue sees issue_ready=0; same cycle as a write-back to x7 -> ready=1 and count stays 3.
- Issue rd=9, write-back x9=0x55 same cycle as rs2=9 read -> with REG_FILE_BYPASS_EN data=0x55 and busy=0; without, data=old value and busy=1, next cycle 0x55/0.
- Write-back x3 with no prior issue -> x3 written, sb_err=1 and stays 1 until rst.
- Issue rd=4, assert rst before write-back -> next cycle x4 busy=0, data 0.
